// File: rtl/core_ctrl_pkg.sv
// core_ctrl_pkg: shared state encoding, RV32I opcode constants and opcode classes.
// No logic; constants and types only.
// No handshake.
package core_ctrl_pkg;

  // Nine states, so the state register is 4 bits wide.
  localparam int ST_W = 4;

  localparam logic [ST_W-1:0] ST_IDLE   = 4'd0;
  localparam logic [ST_W-1:0] ST_FETCH  = 4'd1;
  localparam logic [ST_W-1:0] ST_DECODE = 4'd2;
  localparam logic [ST_W-1:0] ST_EXEC   = 4'd3;
  localparam logic [ST_W-1:0] ST_MEM    = 4'd4;
  localparam logic [ST_W-1:0] ST_WB     = 4'd5;
  localparam logic [ST_W-1:0] ST_BOUND  = 4'd6;
  localparam logic [ST_W-1:0] ST_HALT   = 4'd7;
  localparam logic [ST_W-1:0] ST_FAULT  = 4'd8;

  // RV32I major opcodes, instr[6:0].
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    CLS_ALU    = 3'd0,
    CLS_BRANCH = 3'd1,
    CLS_JUMP   = 3'd2,
    CLS_LOAD   = 3'd3,
    CLS_STORE  = 3'd4,
    CLS_SYSTEM = 3'd5
  } opc_class_e;

endpackage

// File: rtl/stage_sequencer_if.sv
// stage_sequencer_if: control bundle between the stage sequencer and datapath/memories.
// No storage, zero latency.
// Memory readiness flows in on imem_ready/dmem_ready; stage strobes flow out.
interface stage_sequencer_if;
  import core_ctrl_pkg::*;

  logic            start;
  logic [6:0]      instr_opcode;
  logic            imem_ready;
  logic            dmem_ready;
  logic            branch_taken;
  logic            imem_req;
  logic            id_en;
  logic            ex_en;
  logic            mem_req;
  logic            mem_we;
  logic            wb_en;
  logic            pc_en;
  logic            pc_sel_branch;
  logic            halted;
  logic            fault;
  logic [ST_W-1:0] state;
`ifdef RETIRE_COUNT_EN
  logic [31:0]     instret;
`endif

  modport master (
    input  start, instr_opcode, imem_ready, dmem_ready, branch_taken,
    output imem_req, id_en, ex_en, mem_req, mem_we, wb_en, pc_en, pc_sel_branch,
    output halted, fault, state
`ifdef RETIRE_COUNT_EN
    , output instret
`endif
  );

  modport slave (
    output start, instr_opcode, imem_ready, dmem_ready, branch_taken,
    input  imem_req, id_en, ex_en, mem_req, mem_we, wb_en, pc_en, pc_sel_branch,
    input  halted, fault, state
`ifdef RETIRE_COUNT_EN
    , input instret
`endif
  );

endinterface

// File: rtl/opcode_classifier.sv
// opcode_classifier: maps an RV32I major opcode to its class and a legal flag.
// Purely combinational, zero latency.
// No handshake.
module opcode_classifier
  import core_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  output opc_class_e class_o,
  output logic       legal_o
);

  // Table lookup; anything not listed is illegal.
  always_comb begin
    class_o = CLS_ALU;
    legal_o = 1'b1;
    case (opcode_i)
      OPC_LUI, OPC_AUIPC, OPC_OP_IMM, OPC_OP: class_o = CLS_ALU;
      OPC_JAL, OPC_JALR:                      class_o = CLS_JUMP;
      OPC_BRANCH:                             class_o = CLS_BRANCH;
      OPC_LOAD:                               class_o = CLS_LOAD;
      OPC_STORE:                              class_o = CLS_STORE;
      OPC_SYSTEM:                             class_o = CLS_SYSTEM;
      default:                                legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/stage_sequencer.sv
// stage_sequencer: multi-cycle RV32I control FSM issuing one stage strobe per cycle.
// Latency: ALU 5, branch 4, load 6, store 5 cycles plus memory wait cycles.
// Stalls on imem_ready/dmem_ready, faults after MEM_TIMEOUT waits; RETIRE_COUNT_EN adds instret.
module stage_sequencer
  import core_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TMO_W       = 4
) (
  input logic                clk,
  input logic                rst,
  stage_sequencer_if.master  sq_io
);

  localparam logic [TMO_W-1:0] WAIT_LIMIT = TMO_W'(MEM_TIMEOUT - 1);

  logic [ST_W-1:0]  state_q, state_d;
  opc_class_e       cls_q, cls_d;
  logic             br_q, br_d;
  logic [TMO_W-1:0] wait_q, wait_d;

  opc_class_e       dec_cls;
  logic             dec_legal;

  opcode_classifier u_classifier (
    .opcode_i (sq_io.instr_opcode),
    .class_o  (dec_cls),
    .legal_o  (dec_legal)
  );

  // Next-state logic; the wait counter is shared by FETCH and MEM and is zero on entry to either.
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    br_d    = br_q;
    wait_d  = wait_q;
    case (state_q)
      ST_IDLE: begin
        if (sq_io.start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (sq_io.imem_ready) begin
          state_d = ST_DECODE;
          wait_d  = '0;
        end else if (wait_q == WAIT_LIMIT) begin
          state_d = ST_FAULT;
          wait_d  = '0;
        end else begin
          wait_d  = wait_q + TMO_W'(1);
        end
      end
      ST_DECODE: begin
        cls_d = dec_cls;
        if (!dec_legal)                state_d = ST_FAULT;
        else if (dec_cls == CLS_SYSTEM) state_d = ST_HALT;
        else                           state_d = ST_EXEC;
      end
      ST_EXEC: begin
        case (cls_q)
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          CLS_BRANCH: begin
            state_d = ST_BOUND;
            br_d    = sq_io.branch_taken;
          end
          CLS_JUMP: begin
            state_d = ST_WB;
            br_d    = 1'b1;
          end
          default: begin
            state_d = ST_WB;
            br_d    = 1'b0;
          end
        endcase
      end
      ST_MEM: begin
        if (sq_io.dmem_ready) begin
          state_d = (cls_q == CLS_LOAD) ? ST_WB : ST_BOUND;
          br_d    = 1'b0;
          wait_d  = '0;
        end else if (wait_q == WAIT_LIMIT) begin
          state_d = ST_FAULT;
          wait_d  = '0;
        end else begin
          wait_d  = wait_q + TMO_W'(1);
        end
      end
      ST_WB: begin
        state_d = ST_BOUND;
      end
      ST_BOUND: begin
        br_d    = 1'b0;
        state_d = sq_io.start ? ST_FETCH : ST_IDLE;
      end
      ST_HALT, ST_FAULT: begin
        state_d = state_q;
      end
      default: begin
        state_d = ST_FAULT;
      end
    endcase
  end

  // State, class, branch flag and wait counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cls_q   <= CLS_ALU;
      br_q    <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      br_q    <= br_d;
      wait_q  <= wait_d;
    end
  end

  // Moore outputs: decoded from registered state only, so reset clears them immediately.
  assign sq_io.imem_req      = (state_q == ST_FETCH);
  assign sq_io.id_en         = (state_q == ST_DECODE);
  assign sq_io.ex_en         = (state_q == ST_EXEC);
  assign sq_io.mem_req       = (state_q == ST_MEM);
  assign sq_io.mem_we        = (state_q == ST_MEM) && (cls_q == CLS_STORE);
  assign sq_io.wb_en         = (state_q == ST_WB);
  assign sq_io.pc_en         = (state_q == ST_BOUND);
  assign sq_io.pc_sel_branch = (state_q == ST_BOUND) && br_q;
  assign sq_io.halted        = (state_q == ST_HALT);
  assign sq_io.fault         = (state_q == ST_FAULT);
  assign sq_io.state         = state_q;

`ifdef RETIRE_COUNT_EN
  logic [31:0] instret_q, instret_d;

  // Retired-instruction count: one per BOUND cycle, wrapping naturally.
  always_comb begin
    instret_d = instret_q;
    if (state_q == ST_BOUND) instret_d = instret_q + 32'd1;
  end

  // Retire counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) instret_q <= '0;
    else     instret_q <= instret_d;
  end

  assign sq_io.instret = instret_q;
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer: directed stimulus with a strobe scoreboard for stage_sequencer.
// Expected strobe words are queued at issue; a forked monitor pops one per active cycle.
// Define RETIRE_COUNT_EN to also check the retire counter.
module tb_stage_sequencer;
  import core_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  int checks = 0;
  int errors = 0;
  int bounds = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [6:0] op;
    logic       br;
    int         iw;
    int         dw;
    logic       cont;
    logic       mem;
    logic       we;
    logic       wb;
    logic       sel;
    int         lat;
    string      name;
  } vec_t;

  vec_t tbl[12];

  stage_sequencer_if sq_if ();

  stage_sequencer #(
    .MEM_TIMEOUT (15),
    .TMO_W       (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .sq_io (sq_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end, got timeout required finish");
    $fatal(1);
  end

  function automatic logic [7:0] strobes();
    return {sq_if.imem_req, sq_if.id_en, sq_if.ex_en, sq_if.mem_req,
            sq_if.mem_we, sq_if.wb_en, sq_if.pc_en, sq_if.pc_sel_branch};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_strobes", 32'(strobes()), 32'h0);
    chk("rst_halted", 32'(sq_if.halted), 32'h0);
    chk("rst_fault", 32'(sq_if.fault), 32'h0);
    chk("rst_state", 32'(sq_if.state), 32'(ST_IDLE));
`ifdef RETIRE_COUNT_EN
    chk("rst_instret", sq_if.instret, 32'h0);
`endif
    bounds = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    sq_if.start = 1'b0;
    sq_if.imem_ready = 1'b0;
    sq_if.dmem_ready = 1'b0;
    sq_if.branch_taken = 1'b0;
    @(posedge clk); #1;
  endtask

  // Called at posedge+1 with the DUT in IDLE or BOUND; returns at posedge+1 in this instruction's BOUND.
  task automatic run_vec(input vec_t t);
    int t0;
    for (int j = 0; j <= t.iw; j++) exp_q.push_back(8'h80);
    exp_q.push_back(8'h40);
    exp_q.push_back(8'h20);
    if (t.mem) for (int j = 0; j <= t.dw; j++) exp_q.push_back({4'b0001, t.we, 3'b000});
    if (t.wb) exp_q.push_back(8'h04);
    exp_q.push_back({7'b0000001, t.sel});
    t0 = cyc;
    sq_if.start = 1'b1;
    sq_if.instr_opcode = t.op;
    sq_if.branch_taken = t.br;
    sq_if.imem_ready = 1'b0;
    sq_if.dmem_ready = 1'b0;
    for (int j = 1; j <= t.iw + 1; j++) begin
      @(posedge clk); #1;
      sq_if.start = t.cont;
      sq_if.imem_ready = (j == t.iw + 1);
    end
    @(posedge clk); #1;
    sq_if.imem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    if (t.mem) begin
      for (int j = 1; j <= t.dw + 1; j++) begin
        sq_if.dmem_ready = (j == t.dw + 1);
        @(posedge clk); #1;
      end
      sq_if.dmem_ready = 1'b0;
    end
    if (t.wb) begin
      @(posedge clk); #1;
    end
    chk($sformatf("%s_latency", t.name), cyc - t0, t.lat);
    chk($sformatf("%s_pc_en", t.name), 32'(sq_if.pc_en), 32'h1);
    bounds++;
    if (!t.cont) begin
      @(posedge clk); #1;
      chk($sformatf("%s_to_idle", t.name), 32'(sq_if.state), 32'(ST_IDLE));
    end
  endtask

  // SYSTEM or illegal opcode: FETCH, DECODE, then an absorbing HALT/FAULT.
  task automatic run_stop(input logic [6:0] op, input logic exp_halt, input string name);
    exp_q.push_back(8'h80);
    exp_q.push_back(8'h40);
    sq_if.start = 1'b1;
    sq_if.instr_opcode = op;
    sq_if.imem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk($sformatf("%s_halted", name), 32'(sq_if.halted), 32'(exp_halt));
    chk($sformatf("%s_fault", name), 32'(sq_if.fault), 32'(!exp_halt));
    chk($sformatf("%s_state", name), 32'(sq_if.state), exp_halt ? 32'd7 : 32'd8);
    sq_if.dmem_ready = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
    end
    chk($sformatf("%s_sticky_halted", name), 32'(sq_if.halted), 32'(exp_halt));
    chk($sformatf("%s_sticky_fault", name), 32'(sq_if.fault), 32'(!exp_halt));
`ifdef RETIRE_COUNT_EN
    chk($sformatf("%s_instret_frozen", name), sq_if.instret, 32'(bounds));
`endif
  endtask

  initial begin
    //         op            br    iw  dw cont  mem   we    wb    sel   lat name
    tbl[0]  = '{OPC_OP,     1'b0, 0,  0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5,  "alu_op"};
    tbl[1]  = '{OPC_OP_IMM, 1'b1, 0,  0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5,  "alu_imm"};
    tbl[2]  = '{OPC_LUI,    1'b0, 0,  0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5,  "lui_stop"};
    tbl[3]  = '{OPC_BRANCH, 1'b1, 0,  0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4,  "br_taken"};
    tbl[4]  = '{OPC_BRANCH, 1'b0, 0,  0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4,  "br_not"};
    tbl[5]  = '{OPC_JAL,    1'b0, 0,  0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5,  "jal"};
    tbl[6]  = '{OPC_JALR,   1'b0, 0,  0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5,  "jalr"};
    tbl[7]  = '{OPC_LOAD,   1'b0, 0,  3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 9,  "load_wait3"};
    tbl[8]  = '{OPC_STORE,  1'b0, 0,  1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6,  "store_wait1"};
    tbl[9]  = '{OPC_AUIPC,  1'b0, 2,  0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 7,  "auipc_iwait2"};
    tbl[10] = '{OPC_OP,     1'b0, 14, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 19, "fetch_ready_at_limit"};
    tbl[11] = '{OPC_LOAD,   1'b0, 0,  0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6,  "load_nowait"};

    sq_if.start = 1'b0;
    sq_if.instr_opcode = 7'h00;
    sq_if.imem_ready = 1'b0;
    sq_if.dmem_ready = 1'b0;
    sq_if.branch_taken = 1'b0;

    fork
      begin : monitor
        logic [7:0] v;
        forever begin
          @(negedge clk);
          v = strobes();
          if (!rst && v != 8'h00) begin
            if (exp_q.size() == 0) chk("unexpected_strobe", 32'(v), 32'h0);
            else                   chk("strobe_seq", 32'(v), 32'(exp_q.pop_front()));
          end
        end
      end
    join_none

    #3;
    do_reset();

    foreach (tbl[i]) run_vec(tbl[i]);
`ifdef RETIRE_COUNT_EN
    chk("instret_count", sq_if.instret, 32'(bounds));
`endif

    // Fetch timeout: 15 FETCH cycles with no ready, then FAULT.
    repeat (15) exp_q.push_back(8'h80);
    sq_if.start = 1'b1;
    sq_if.imem_ready = 1'b0;
    sq_if.dmem_ready = 1'b1;
    repeat (15) begin
      @(posedge clk); #1;
    end
    chk("tmo_no_early_fault", 32'(sq_if.fault), 32'h0);
    chk("tmo_still_fetch", 32'(sq_if.state), 32'(ST_FETCH));
    @(posedge clk); #1;
    chk("tmo_fault", 32'(sq_if.fault), 32'h1);
    chk("tmo_not_halted", 32'(sq_if.halted), 32'h0);
    chk("tmo_state", 32'(sq_if.state), 32'(ST_FAULT));
    do_reset();

    run_stop(OPC_SYSTEM, 1'b1, "ecall");
    do_reset();
    run_stop(7'b1111111, 1'b0, "illegal");
    do_reset();

    // Reset while MEM is waiting: outputs drop at once, no pc_en/wb_en follows.
    exp_q.push_back(8'h80);
    exp_q.push_back(8'h40);
    exp_q.push_back(8'h20);
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h10);
    sq_if.start = 1'b1;
    sq_if.instr_opcode = OPC_LOAD;
    sq_if.imem_ready = 1'b1;
    sq_if.dmem_ready = 1'b0;
    @(posedge clk); #1;
    sq_if.start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("mid_mem_req", 32'(sq_if.mem_req), 32'h1);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    chk("async_rst_mem_req", 32'(sq_if.mem_req), 32'h0);
    chk("async_rst_strobes", 32'(strobes()), 32'h0);
    chk("async_rst_state", 32'(sq_if.state), 32'(ST_IDLE));
    @(posedge clk); #1;
    rst = 1'b0;
    sq_if.dmem_ready = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("post_rst_idle", 32'(sq_if.state), 32'(ST_IDLE));

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
